// File: rtl/aes_spi_slave.sv
// aes_spi_slave: SPI target front-end for an AES encrypt/decrypt core.
// Deserialises {message, key} from Mosi, pulses core_start, waits for
// core_done and serialises the 128-bit result on Miso, MSB first.
// Optional feature macro: AES_SPI_STATUS_HDR_EN prefixes the result with
// an 8'hA5 status header (136 TX bits instead of 128).
module aes_spi_slave #(
  parameter int unsigned nk = 4,
  parameter int unsigned nb = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              Mosi,
  output logic              Miso,
  output logic [32*nb-1:0]  core_msg,
  output logic [32*nk-1:0]  core_key,
  output logic              core_start,
  input  logic              core_done,
  input  logic [32*nb-1:0]  core_result,
  output logic              busy
);

  localparam int unsigned MW = 32 * nb;
  localparam int unsigned KW = 32 * nk;
  localparam int unsigned L  = MW + KW;
  localparam int unsigned CW = $clog2(L + 1);
`ifdef AES_SPI_STATUS_HDR_EN
  localparam int unsigned HW = 8;
`else
  localparam int unsigned HW = 0;
`endif
  localparam int unsigned T  = MW + HW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    TX    = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [L-1:0]   rx_sr, rx_nxt;
  logic [T-1:0]   tx_sr, tx_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           miso_nxt;
  logic           start_nxt;
  logic           busy_nxt;
  logic [T-1:0]   payload;

  // Parallel views of the receive shift register: message first, key last
  assign core_msg = rx_sr[L-1 -: MW];
  assign core_key = rx_sr[KW-1:0];

  // TX frame: optional status header followed by the core result
`ifdef AES_SPI_STATUS_HDR_EN
  assign payload = {8'hA5, core_result};
`else
  assign payload = core_result;
`endif

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt = state;
    rx_nxt    = rx_sr;
    tx_nxt    = tx_sr;
    cnt_nxt   = cnt;
    miso_nxt  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cs) begin
          rx_nxt    = {rx_sr[L-2:0], Mosi};
          cnt_nxt   = CW'(1);
          state_nxt = RX;
        end
      end
      RX: begin
        rx_nxt  = {rx_sr[L-2:0], Mosi};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(L - 1)) begin
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          tx_nxt    = payload;
          miso_nxt  = payload[T-1];
          cnt_nxt   = '0;
          state_nxt = TX;
        end
      end
      TX: begin
        if (cnt == CW'(T - 1)) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          tx_nxt   = {tx_sr[T-2:0], 1'b0};
          miso_nxt = tx_sr[T-2];
          cnt_nxt  = cnt + CW'(1);
        end
      end
      HOLD: begin
        state_nxt = HOLD;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Dropping chip-select aborts any transaction on the next edge
    if (!cs) begin
      state_nxt = IDLE;
      rx_nxt    = rx_sr;
      tx_nxt    = tx_sr;
      cnt_nxt   = '0;
      miso_nxt  = 1'b0;
    end

    start_nxt = (state_nxt == START);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_sr      <= '0;
      tx_sr      <= '0;
      cnt        <= '0;
      Miso       <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_sr      <= rx_nxt;
      tx_sr      <= tx_nxt;
      cnt        <= cnt_nxt;
      Miso       <= miso_nxt;
      core_start <= start_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
